// File: rtl/comb_debounce.sv
// rtl/comb_debounce.sv - multi-channel synchroniser, debounce filter and edge detector
module comb_debounce #(
    parameter int CH          = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = $clog2(DEBOUNCE + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CH-1:0] in,
    output logic [CH-1:0] out,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall
);

    // Terminal count: a difference seen on this many consecutive edges commits.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Synchroniser chain, one packed vector of all channels per stage.
    logic [CH-1:0] sync [SYNC_STAGES];
    logic [CH-1:0] s;

    // Per-channel filter state and its next values.
    logic [CNT_W-1:0] cnt      [CH];
    logic [CNT_W-1:0] cnt_next [CH];
    logic [CH-1:0]    out_next;
    logic [CH-1:0]    rise_next;
    logic [CH-1:0]    fall_next;

    assign s = sync[SYNC_STAGES-1];

    // Metastability chain; keeps running regardless of en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync[k] <= '0;
            end
        end else begin
            sync[0] <= in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync[k] <= sync[k-1];
            end
        end
    end

    // Stability counter decision per channel: disable, agree, commit, or keep counting.
    always_comb begin
        out_next  = out;
        rise_next = '0;
        fall_next = '0;
        for (int i = 0; i < CH; i++) begin
            cnt_next[i] = cnt[i];
            if (!en) begin
                cnt_next[i] = '0;
            end else if (s[i] == out[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                cnt_next[i]  = '0;
                out_next[i]  = s[i];
                rise_next[i] = s[i];
                fall_next[i] = ~s[i];
            end else begin
                cnt_next[i] = cnt[i] + CNT_ONE;
            end
        end
    end

    // Filter state and registered edge pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                cnt[i] <= '0;
            end
            out  <= '0;
            rise <= '0;
            fall <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                cnt[i] <= cnt_next[i];
            end
            out  <= out_next;
            rise <= rise_next;
            fall <= fall_next;
        end
    end

endmodule

// File: tb/tb_comb_debounce.sv
// tb/tb_comb_debounce.sv - scoreboard bench for comb_debounce
module tb_comb_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b1;
    logic [1:0] in  = 2'b00;
    logic [1:0] out;
    logic [1:0] rise;
    logic [1:0] fall;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        int         cyc;
        logic [1:0] o;
        logic [1:0] r;
        logic [1:0] f;
    } ev_t;

    ev_t q[$];

    comb_debounce #(
        .CH(2),
        .SYNC_STAGES(2),
        .DEBOUNCE(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .in(in),
        .out(out),
        .rise(rise),
        .fall(fall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic expect_ev(input int c, input logic [1:0] o, input logic [1:0] r,
                             input logic [1:0] f);
        ev_t e;
        e.cyc = c;
        e.o   = o;
        e.r   = r;
        e.f   = f;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every pulse must match the head of the expected queue.
    always @(negedge clk) begin
        ev_t e;
        if ((rise | fall) != 2'b00) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", {26'd0, out, rise, fall}, 0);
            end else begin
                e = q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_out", int'(out), int'(e.o));
                check("pulse_rise", int'(rise), int'(e.r));
                check("pulse_fall", int'(fall), int'(e.f));
            end
        end else if (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            check("missed_pulse_cycle", cyc, e.cyc);
        end
    end

    initial begin
        int t;
        #1;
        rst = 1'b1;
        in  = 2'b11;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("reset_outputs", {26'd0, out, rise, fall}, 0);
        end

        // Release: both channels rise 6 edges later
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_ev(cyc + 6, 2'b11, 2'b11, 2'b00);
        tick(10);
        in = 2'b00;
        expect_ev(cyc + 6, 2'b00, 2'b00, 2'b11);
        tick(10);

        // Clean step on channel 0
        in = 2'b01;
        expect_ev(cyc + 6, 2'b01, 2'b01, 2'b00);
        tick(10);
        check("step_out_held", int'(out), 1);
        in = 2'b00;
        expect_ev(cyc + 6, 2'b00, 2'b00, 2'b01);
        tick(10);

        // Glitch of 3 cycles on channel 1 is rejected
        in = 2'b10;
        tick(3);
        in = 2'b00;
        tick(10);
        check("glitch_out", int'(out), 0);

        // 4-cycle pulse passes with one rise and one fall
        in = 2'b10;
        expect_ev(cyc + 6, 2'b10, 2'b10, 2'b00);
        expect_ev(cyc + 10, 2'b00, 2'b00, 2'b10);
        tick(4);
        in = 2'b00;
        tick(12);

        // Bounce: toggle every 2 cycles for 20 cycles, then hold high
        t = cyc;
        for (int k = 0; k < 10; k++) begin
            in = (k % 2 == 0) ? 2'b01 : 2'b00;
            tick(2);
        end
        check("bounce_span", cyc - t, 20);
        check("bounce_out", int'(out), 0);
        in = 2'b01;
        expect_ev(cyc + 6, 2'b01, 2'b01, 2'b00);
        tick(10);
        in = 2'b00;
        expect_ev(cyc + 6, 2'b00, 2'b00, 2'b01);
        tick(10);

        // Simultaneous step, then channel 1 alone
        in = 2'b11;
        expect_ev(cyc + 6, 2'b11, 2'b11, 2'b00);
        tick(10);
        in = 2'b01;
        expect_ev(cyc + 6, 2'b01, 2'b00, 2'b10);
        tick(10);
        check("independent_out", int'(out), 1);
        in = 2'b00;
        expect_ev(cyc + 6, 2'b00, 2'b00, 2'b01);
        tick(10);

        // Enable dropped mid-count restarts the count
        in = 2'b01;
        t  = cyc;
        expect_ev(t + 13, 2'b01, 2'b01, 2'b00);
        tick(4);
        en = 1'b0;
        tick(5);
        check("en_low_out", int'(out), 0);
        en = 1'b1;
        tick(8);
        check("en_restore_out", int'(out), 1);
        in = 2'b00;
        expect_ev(cyc + 6, 2'b00, 2'b00, 2'b01);
        tick(10);

        // Mid-operation reset clears outputs at once, no pulse follows
        in = 2'b10;
        expect_ev(cyc + 6, 2'b10, 2'b10, 2'b00);
        tick(10);
        in = 2'b11;
        tick(3);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {26'd0, out, rise, fall}, 0);
        tick(2);
        in  = 2'b00;
        rst = 1'b0;
        tick(15);
        check("final_out", int'(out), 0);
        check("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/comb_debounce.md
# comb_debounce

Parametrised, multi-channel input conditioner. It turns asynchronous level inputs (switches, strobes, external flags) into clean, synchronised, glitch-filtered levels, plus one-cycle rise and fall pulses per channel. It generalises the two-channel combinational pass-through to CH channels and adds synchronisation, debounce filtering, edge detection and a global enable. It sits at the chip boundary, ahead of any FSM that consumes external levels.

## Interface
Parameters:
- CH, default 2: number of independent channels, ≥1.
- SYNC_STAGES, default 2: synchroniser flop depth per channel, ≥2.
- DEBOUNCE, default 4: consecutive stable cycles required before an output changes, ≥1.
- CNT_W, default $clog2(DEBOUNCE+1): stability counter width. Derived; do not override.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  filter enable, synchronous to clk.
- in  in  CH  raw asynchronous inputs, one bit per channel.
- out  out  CH  filtered, synchronised levels.
- rise  out  CH  one-cycle pulse when out[i] goes 0→1.
- fall  out  CH  one-cycle pulse when out[i] goes 1→0.

## Operation
Each channel is an identical, independent slice. Channels share only clk, rst and en.
- Synchroniser: SYNC_STAGES-deep flop chain on in[i]. The last stage is s[i].
- Stability counter cnt[i] (CNT_W bits), evaluated each cycle in priority order:
  - en=0: cnt←0; out, rise and fall held/cleared as below. The synchroniser keeps running.
  - s[i]==out[i]: cnt←0.
  - s[i]!=out[i] and cnt==DEBOUNCE-1: out[i]←s[i], cnt←0, and pulse rise[i] (new value 1) or fall[i] (new value 0).
  - Otherwise: cnt←cnt+1.
- rise and fall are registered. They are high only in the cycle in which out changes, and are 0 in every other cycle, including all cycles with en=0.
- Glitches: any excursion of s[i] lasting fewer than DEBOUNCE consecutive cycles resets cnt and never reaches out.
- The counter never exceeds DEBOUNCE-1, so it never wraps.
- With DEBOUNCE=1, out follows s with one extra register stage.
- rise[i] and fall[i] are never high together.
- Any combination of channels may change out in the same cycle.
- When en goes 1→0 mid-count, the count is discarded. When en goes back to 1, counting restarts from 0.

## Timing
- Reset values: all synchroniser stages 0, cnt 0, out 0, rise 0, fall 0. All are asserted asynchronously on rst↑ and held while rst=1.
- Reset mid-operation discards any in-progress count and pulse immediately.
- First evaluation happens on the first rising clk edge after rst deasserts.
- Latency, with en=1 throughout: in[i] changes and then stays stable, sampled at edge 1. out[i] and its pulse become visible after edge SYNC_STAGES+DEBOUNCE. Defaults give 6 cycles.
- A change must be stable at s[i] for exactly DEBOUNCE consecutive edges to propagate. DEBOUNCE-1 edges is rejected.
- Pulse width is exactly one clk cycle.
- No combinational path from any input to any output.

## Test plan
All scenarios use defaults (CH=2, SYNC_STAGES=2, DEBOUNCE=4) and en=1 unless stated.
- Reset: hold rst=1 with in=2'b11 for 10 cycles. Required: out=0, rise=0, fall=0 throughout, and rise[0] fires at edge 6 after release.
- Clean step: drive in[0] 0→1, held. Required: out[0]=1 and rise[0]=1 for one cycle after edge 6, then rise[0]=0. Then drive 1→0: fall[0] pulses once, 6 cycles later.
- Glitch rejection: pulse in[1] high for 3 cycles, then low. Required: out[1], rise[1] and fall[1] stay 0. Then a 4-cycle pulse: out[1] goes high for 4 cycles, with exactly one rise and one fall.
- Bounce: toggle in[0] every 2 cycles for 20 cycles, then hold 1. Required: no change on out[0] during the toggling, and a single rise[0] 6 cycles after the last edge.
- Simultaneous and independent channels: step in=2'b00→2'b11 in one cycle. Required: out=2'b11 and rise=2'b11 in the same cycle. Then step in[1] alone: out[0] is unaffected.
- Enable and mid-operation reset:
  - Step in[0] high, drop en after 4 cycles for 5 cycles, then restore. Required: out[0] rises 4 cycles after en returns, and there is no pulse while en=0.
  - Repeat the step, but assert rst 3 cycles in. Required: all outputs 0 immediately, and no pulse follows.
